// File: rtl/rc_driver.sv
// rc_driver
//   Host-side driver for a dual-rail (return-to-zero) asynchronous array.
//   An operand word accepted from the host is encoded one channel per bit
//   onto aout. The block then waits for the array's answer on ain, through
//   a two-flop synchronizer. It captures the answer once it is complete and
//   stable, presents it to the host, and returns aout to all-empty. It then
//   waits for the array to release ain before it takes the next operand.
//
// Ports
//   clk, reset       clock and asynchronous active-high reset
//   in_valid/ready   operand handshake, in_data carries WIDTH operand bits
//   out_valid/ready  result handshake, out_data carries WIDTH result bits
//   err              sticky flags: [1] illegal 11 code seen, [0] timeout
//   aout             dual-rail drive into the array, channel i = [2i+1:2i]
//   ain              dual-rail answer from the array (asynchronous)
//
// Dual-rail code per channel: 00 empty, 01 value 0, 10 value 1, 11 illegal.
module rc_driver #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         err,
  output logic [2*WIDTH-1:0] aout,
  input  logic [2*WIDTH-1:0] ain
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_RES, WAIT_EMPTY} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] syncMeta_q, sa_q, saPrev_q;
  logic [2*WIDTH-1:0] aout_q, aout_d;
  logic               outValid_q, outValid_d;
  logic [WIDTH-1:0]   outData_q, outData_d;
  logic [1:0]         err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               readyEn_q;

  logic               saComplete, saIllegal, saEmpty, saStable;
  logic [CW-1:0]      cntInc;
  logic               cntHit;

  function automatic logic [2*WIDTH-1:0] encodeWord(input logic [WIDTH-1:0] v);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    end
    return r;
  endfunction

  // readyEn_q holds in_ready low during reset and lets it rise on the
  // first clock edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      syncMeta_q <= '0;
      sa_q       <= '0;
      saPrev_q   <= '0;
      aout_q     <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      readyEn_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      syncMeta_q <= ain;
      sa_q       <= syncMeta_q;
      saPrev_q   <= sa_q;
      aout_q     <= aout_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      readyEn_q  <= 1'b1;
    end
  end

  // Classify the synchronized answer. Complete means no channel is empty.
  // A channel carrying 11 marks the whole sample illegal.
  always_comb begin
    saComplete = 1'b1;
    saIllegal  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sa_q[2*i +: 2] == 2'b00) saComplete = 1'b0;
      if (sa_q[2*i +: 2] == 2'b11) saIllegal  = 1'b1;
    end
  end

  assign saEmpty  = (sa_q == '0);
  assign saStable = (sa_q == saPrev_q);
  // The counter saturates. Timeout fires on the edge where it would reach
  // TIMEOUT, i.e. after exactly TIMEOUT cycles in the waiting state.
  assign cntInc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign cntHit   = (cntInc == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    aout_d     = aout_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    if (outValid_q && out_ready) outValid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          aout_d  = encodeWord(in_data);
          err_d   = 2'b00;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d   = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        cnt_d = cntInc;
        if (saIllegal) err_d[1] = 1'b1;
        // Capture only when two consecutive samples are complete, legal and
        // identical, so that skewed or glitching channels have settled.
        if (saComplete && !saIllegal && saStable) begin
          for (int i = 0; i < WIDTH; i++) begin
            outData_d[i] = sa_q[2*i+1];
          end
          outValid_d = 1'b1;
          aout_d     = '0;
          cnt_d      = '0;
          state_d    = WAIT_EMPTY;
        end else if (cntHit) begin
          err_d[0] = 1'b1;
          aout_d   = '0;
          cnt_d    = '0;
          state_d  = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        cnt_d = cntInc;
        if (saEmpty) begin
          state_d = IDLE;
        end else if (cntHit) begin
          err_d[0] = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = readyEn_q && (state_q == IDLE) && !outValid_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign err       = err_q;
  assign aout      = aout_q;

endmodule

// File: tb/tb_rc_driver.sv
// tb_rc_driver
//   Drives operands into rc_driver and plays the part of the asynchronous
//   array on ain. Each response is built from a plan: per-channel arrival
//   delay, an optional one-cycle glitch, an optional two-cycle illegal 11,
//   and a release delay. Expected results go into a queue when an operand is
//   issued. A separate monitor pops them when the host side consumes a result.
module tb_rc_driver;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 20;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       err;
  } exp_t;

  logic               clk, reset;
  logic               in_valid, in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid, out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         err;
  logic [2*WIDTH-1:0] aout, ain;

  int   checks   = 0;
  int   failures = 0;
  exp_t expQ[$];
  bit   holdReady = 1'b0;

  int   planArr[WIDTH];
  int   planGlitch;
  int   planIllegal;
  int   planRelease;
  bit   planRespond;

  rc_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err),
    .aout      (aout),
    .ain       (ain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-rail encoding of a word: 1 -> 10, 0 -> 01.
  function automatic logic [2*WIDTH-1:0] dualRail(input logic [WIDTH-1:0] v);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Issue one operand, then act as the array according to the plan.
  task automatic applyStimulus(input logic [WIDTH-1:0] op, input logic [WIDTH-1:0] fin,
                               input logic [1:0] expErr);
    int               n;
    logic [1:0]       code;
    logic [2*WIDTH-1:0] nextAin;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      failNow("accept_wait");
      return;
    end
    in_valid = 1'b1;
    in_data  = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    checkOutput("aout_drive", 32'(aout), 32'(dualRail(op)));
    checkOutput("err_cleared", 32'(err), 32'(2'b00));
    if (!planRespond) return;
    expQ.push_back('{data: fin, err: expErr});
    n = 0;
    while (aout != '0 && n < 4*TIMEOUT) begin
      nextAin = '0;
      for (int i = 0; i < WIDTH; i++) begin
        code = fin[i] ? 2'b10 : 2'b01;
        if (n < planArr[i])                          code = 2'b00;
        else if (i == planIllegal && n < planArr[i] + 2) code = 2'b11;
        else if (i == planGlitch && n == planArr[i])     code = ~code;
        nextAin[2*i +: 2] = code;
      end
      ain = nextAin;
      n++;
      @(posedge clk); #1;
    end
    if (aout != '0) begin
      failNow("capture_wait");
      return;
    end
    for (int k = 1; k <= planRelease; k++) begin
      @(posedge clk); #1;
      if (planRelease > TIMEOUT) begin
        if (k == TIMEOUT - 1) checkOutput("wait_empty_pre_timeout", 32'(err[0]), 32'd0);
        if (k == TIMEOUT)     checkOutput("wait_empty_timeout", 32'(err[0]), 32'd1);
      end
    end
    ain = '0;
  endtask

  task automatic setPlan(input int arrival, input int glitch, input int illegal, input int rel);
    for (int i = 0; i < WIDTH; i++) planArr[i] = arrival;
    planGlitch  = glitch;
    planIllegal = illegal;
    planRelease = rel;
    planRespond = 1'b1;
  endtask

  // Result monitor: consumes results with random backpressure, compares them
  // against the queue and checks that a stalled result holds still.
  initial begin
    logic [WIDTH-1:0] lastData;
    bit               lastPending;
    exp_t             e;
    out_ready   = 1'b0;
    lastPending = 1'b0;
    lastData    = '0;
    forever begin
      @(posedge clk); #1;
      out_ready = holdReady ? 1'b0 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (reset) begin
        lastPending = 1'b0;
      end else if (out_valid) begin
        if (lastPending) checkOutput("out_data_stable", 32'(out_data), 32'(lastData));
        if (out_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_result actual=%0h required=none", out_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("out_data", 32'(out_data), 32'(e.data));
            checkOutput("out_err", 32'(err), 32'(e.err));
          end
          lastPending = 1'b0;
        end else begin
          lastPending = 1'b1;
          lastData    = out_data;
        end
      end else begin
        lastPending = 1'b0;
      end
    end
  end

  // aout must never step from one non-empty word to a different one.
  initial begin
    logic [2*WIDTH-1:0] prevAout;
    prevAout = '0;
    forever begin
      @(negedge clk);
      if (aout !== prevAout) begin
        checks++;
        if (prevAout != '0 && aout != '0) begin
          failures++;
          $display("[TB] FAIL aout_rtz actual=%0h required=00 after %0h", aout, prevAout);
        end
        prevAout = aout;
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] op, fin;
    int               n;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    ain         = '0;
    setPlan(0, -1, -1, 2);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_aout", 32'(aout), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

    // Basic: operand 1010, array answers 10_01_10_01 after 3 cycles.
    setPlan(3, -1, -1, 2);
    applyStimulus(4'b1010, 4'b1010, 2'b00);

    // Skewed arrival, channel 2 glitches 01 before settling at 10.
    setPlan(0, 2, -1, 3);
    planArr[0] = 2; planArr[1] = 5; planArr[2] = 1; planArr[3] = 3;
    applyStimulus(4'b0011, 4'b0110, 2'b00);

    // Channel 1 reports 11 for two cycles, then 10.
    setPlan(1, -1, 1, 2);
    applyStimulus(4'b1100, 4'b1010, 2'b10);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      setPlan(0, -1, -1, $urandom_range(1, 4));
      for (int i = 0; i < WIDTH; i++) planArr[i] = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) planGlitch = $urandom_range(0, WIDTH-1);
      if ($urandom_range(0, 3) == 0) begin
        planIllegal = $urandom_range(0, WIDTH-1);
        if (planIllegal == planGlitch) planIllegal = (planIllegal + 1) % WIDTH;
      end
      op  = WIDTH'($urandom);
      fin = WIDTH'($urandom);
      applyStimulus(op, fin, (planIllegal >= 0) ? 2'b10 : 2'b00);
    end

    // Backpressure: result held for 10 cycles while a new operand is offered.
    holdReady = 1'b1;
    setPlan(2, -1, -1, 1);
    applyStimulus(4'b0101, 4'b1001, 2'b00);
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    if (!out_valid) failNow("bp_result_wait");
    in_valid = 1'b1;
    in_data  = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_aout_idle", 32'(aout), 32'd0);
    end
    in_valid  = 1'b0;
    holdReady = 1'b0;
    n = 0;
    while (out_valid && n < 40) begin @(posedge clk); #1; n++; end
    checkOutput("bp_out_valid_clear", 32'(out_valid), 32'd0);
    checkOutput("bp_in_ready_rise", 32'(in_ready), 32'd1);

    // Timeout in WAIT_RES: the array never answers.
    planRespond = 1'b0;
    applyStimulus(4'b0110, 4'b0000, 2'b00);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      @(posedge clk); #1;
      if (k == TIMEOUT) begin
        checkOutput("wait_res_pre_timeout", 32'(err), 32'd0);
        checkOutput("wait_res_aout_held", 32'(aout), 32'(dualRail(4'b0110)));
      end
    end
    checkOutput("wait_res_timeout_err", 32'(err), 32'(2'b01));
    checkOutput("wait_res_timeout_aout", 32'(aout), 32'd0);
    checkOutput("wait_res_timeout_valid", 32'(out_valid), 32'd0);
    n = 0;
    while (!in_ready && n < 2*TIMEOUT + 5) begin @(posedge clk); #1; n++; end
    checkOutput("timeout_back_idle", 32'(in_ready), 32'd1);
    checkOutput("timeout_err_sticky", 32'(err), 32'(2'b01));

    // Timeout in WAIT_EMPTY: the array keeps its answer past TIMEOUT.
    holdReady = 1'b1;
    setPlan(1, -1, -1, TIMEOUT + 3);
    applyStimulus(4'b1001, 4'b0111, 2'b01);
    holdReady = 1'b0;

    // Asynchronous reset while waiting for the array.
    n = 0;
    while (expQ.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    planRespond = 1'b0;
    applyStimulus(4'b1110, 4'b0000, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_aout", 32'(aout), 32'(dualRail(4'b1110)));
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_aout", 32'(aout), 32'd0);
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_err", 32'(err), 32'd0);
    checkOutput("async_reset_data", 32'(out_data), 32'd0);
    checkOutput("async_reset_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_reset_ready", 32'(in_ready), 32'd1);

    // One more full transaction after reset.
    setPlan(2, -1, -1, 2);
    applyStimulus(4'b0001, 4'b1000, 2'b00);

    n = 0;
    while (expQ.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("queue_drain", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
